// File: rtl/mult_operand_sequencer_if.sv
// Bus bundle between the operand sequencer, its upstream producer, the sequential
// multiplier and the downstream product consumer.
interface mult_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mul_load;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_product;
    logic        mul_valid;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;

    modport master (
        input  in_valid, in_a, in_b, mul_product, mul_valid, out_ready,
        output in_ready, mul_load, mul_a, mul_b, out_valid, out_product
    );

    modport slave (
        output in_valid, in_a, in_b, mul_product, mul_valid, out_ready,
        input  in_ready, mul_load, mul_a, mul_b, out_valid, out_product
    );
endinterface

// File: rtl/mult_operand_sequencer.sv
// Queues operand pairs and feeds them one at a time to a sequential multiplier,
// capturing each product (or aborting on timeout) before issuing the next.
module mult_operand_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          asyn_rst,
    mult_operand_sequencer_if.master      bus,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
    output logic                          timeout_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [7:0]        mul_a_q, mul_a_d;
    logic [7:0]        mul_b_q, mul_b_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_product_q, out_product_d;
    logic              timeout_err_q, timeout_err_d;
    logic [15:0]       mem_q [DEPTH];
    logic              push, pop;

    assign bus.in_ready    = (count_q < CntW'(DEPTH));
    assign bus.mul_load    = (state_q == StLoad);
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign fifo_count      = count_q;
    assign timeout_err     = timeout_err_q;

    assign push = bus.in_valid && bus.in_ready;

    // Operand storage carries no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        timeout_err_d = 1'b0;
        pop           = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StLoad;
                    {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
                end
            end
            StLoad: begin
                pop     = 1'b1;
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // A valid seen with timer == 0 is left over from the previous multiply.
                if ((timer_q != '0) && bus.mul_valid) begin
                    out_product_d = bus.mul_product;
                    out_valid_d   = 1'b1;
                    state_d       = StHold;
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StHold: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            timeout_err_q <= timeout_err_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural 8-cycle multiplier model.
module tb_mult_operand_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int          MUL_LAT = 8;

    logic       clk      = 1'b0;
    logic       asyn_rst = 1'b0;
    logic [2:0] fifo_count;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int te_cnt = 0;

    mult_operand_sequencer_if bus ();

    mult_operand_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .asyn_rst    (asyn_rst),
        .bus         (bus),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mul_load === 1'b1) load_cnt++;
        if (timeout_err === 1'b1) te_cnt++;
    end

    // Multiplier model: product after MUL_LAT cycles; optionally never answers, or
    // keeps its valid asserted until one cycle after the next load (stale valid).
    bit          mdl_never = 1'b0;
    bit          mdl_stale = 1'b0;
    bit          mdl_busy;
    bit          mdl_drop;
    int          mdl_cnt;
    logic [15:0] mdl_prod;

    always @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            bus.mul_valid   <= 1'b0;
            bus.mul_product <= '0;
            mdl_busy        <= 1'b0;
            mdl_drop        <= 1'b0;
            mdl_cnt         <= 0;
            mdl_prod        <= '0;
        end else begin
            if (mdl_drop) begin
                bus.mul_valid <= 1'b0;
                mdl_drop      <= 1'b0;
            end
            if (bus.mul_load === 1'b1) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= MUL_LAT;
                mdl_prod <= 16'(bus.mul_a) * 16'(bus.mul_b);
                if (mdl_stale) mdl_drop <= 1'b1;
                else bus.mul_valid <= 1'b0;
            end else if (mdl_busy) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) begin
                    mdl_busy <= 1'b0;
                    if (!mdl_never) begin
                        bus.mul_valid   <= 1'b1;
                        bus.mul_product <= mdl_prod;
                    end
                end
            end else if (!mdl_stale) begin
                bus.mul_valid <= 1'b0;
            end
        end
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept: in_ready=%b after %0d cycles, want 1", bus.in_ready, waited);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        asyn_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        if (bus.mul_load !== 1'b0) begin errors++; $display("FAIL rst_mul_load: got %b want 0", bus.mul_load); end
        if (bus.mul_a !== 8'h00) begin errors++; $display("FAIL rst_mul_a: got %h want 00", bus.mul_a); end
        if (bus.mul_b !== 8'h00) begin errors++; $display("FAIL rst_mul_b: got %h want 00", bus.mul_b); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_product !== 16'h0) begin errors++; $display("FAIL rst_out_product: got %h want 0000", bus.out_product); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        asyn_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_op();
        int l0 = load_cnt;
        bit seen;
        bus.in_a = 8'hB7; bus.in_b = 8'hC5; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks += 2;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_push: got %0d want 1", fifo_count); end
        if (bus.mul_load !== 1'b0) begin errors++; $display("FAIL single_load_early: got %b want 0", bus.mul_load); end
        @(negedge clk);
        checks += 3;
        if (bus.mul_load !== 1'b1) begin errors++; $display("FAIL single_load_latency: got %b want 1", bus.mul_load); end
        if (bus.mul_a !== 8'hB7) begin errors++; $display("FAIL single_mul_a: got %h want b7", bus.mul_a); end
        if (bus.mul_b !== 8'hC5) begin errors++; $display("FAIL single_mul_b: got %h want c5", bus.mul_b); end
        @(negedge clk);
        checks += 2;
        if (bus.mul_load !== 1'b0) begin errors++; $display("FAIL single_load_pulse: got %b want 0", bus.mul_load); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d want 0", fifo_count); end
        wait_out_valid(40, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL single_out_valid: got none want 1 within 40 cycles"); end
        if (bus.out_product !== 16'h8CD3) begin errors++; $display("FAIL single_product: got %h want 8cd3", bus.out_product); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_product !== 16'h8CD3) begin
            errors++;
            $display("FAIL single_hold: got valid=%b prod=%h want 1/8cd3", bus.out_valid, bus.out_product);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", bus.out_valid); end
        if (load_cnt - l0 != 1) begin errors++; $display("FAIL single_load_count: got %0d want 1", load_cnt - l0); end
        if (bus.mul_a !== 8'hB7) begin errors++; $display("FAIL single_mul_a_hold: got %h want b7", bus.mul_a); end
    endtask

    task automatic test_burst();
        logic [7:0]  ba [5] = '{8'hB7, 8'h95, 8'h12, 8'hFF, 8'h00};
        logic [7:0]  bb [5] = '{8'hC5, 8'h67, 8'h34, 8'hFF, 8'h5A};
        logic [15:0] bexp [5] = '{16'h8CD3, 16'h3BF3, 16'h03A8, 16'hFE01, 16'h0000};
        int got = 0;
        int te0 = te_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_pair(ba[i], bb[i]);
        checks += 2;
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL burst_full_count: got %0d want 4", fifo_count); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL burst_in_ready_full: got %b want 0", bus.in_ready); end
        for (int c = 0; c < 300 && got < 5; c++) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_product !== bexp[got]) begin
                    errors++;
                    $display("FAIL burst_product_%0d: got %h want %h", got, bus.out_product, bexp[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        checks += 3;
        if (got != 5) begin errors++; $display("FAIL burst_product_count: got %0d want 5", got); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL burst_drained: got %0d want 0", fifo_count); end
        if (te_cnt != te0) begin errors++; $display("FAIL burst_no_timeout: got %0d pulses want 0", te_cnt - te0); end
    endtask

    task automatic test_backpressure();
        int l0;
        int bad = 0;
        bit seen;
        bus.out_ready = 1'b0;
        push_pair(8'h95, 8'h67);
        push_pair(8'h12, 8'h34);
        wait_out_valid(60, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL bp_out_valid: got none want 1 within 60 cycles"); end
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL bp_count: got %0d want 1", fifo_count); end
        l0 = load_cnt;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_product !== 16'h3BF3 || fifo_count !== 3'd1) bad++;
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        if (load_cnt != l0) begin errors++; $display("FAIL bp_no_load: got %0d loads want 0", load_cnt - l0); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        wait_out_valid(60, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL bp_second_valid: got none want 1 within 60 cycles"); end
        if (bus.out_product !== 16'h03A8) begin errors++; $display("FAIL bp_second_product: got %h want 03a8", bus.out_product); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int te0 = te_cnt;
        int te_idx = -1;
        int ld_idx = -1;
        bit found = 1'b0;
        bit ov_seen = 1'b0;
        bit seen;
        mdl_never = 1'b1;
        bus.out_ready = 1'b1;
        push_pair(8'h11, 8'h22);
        push_pair(8'h03, 8'h04);
        for (int i = 0; i < 10; i++) begin
            if (bus.mul_load === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found || bus.mul_a !== 8'h11) begin
            errors++;
            $display("FAIL to_first_load: got found=%b a=%h want 1/11", found, bus.mul_a);
        end
        for (int n = 1; n <= int'(TIMEOUT) + 5; n++) begin
            @(negedge clk);
            if (timeout_err === 1'b1 && te_idx < 0) te_idx = n;
            if (bus.mul_load === 1'b1 && bus.mul_a === 8'h03 && bus.mul_b === 8'h04 && ld_idx < 0)
                ld_idx = n;
            if (bus.out_valid === 1'b1) ov_seen = 1'b1;
        end
        mdl_never = 1'b0;
        checks += 4;
        if (te_idx != int'(TIMEOUT) + 1) begin errors++; $display("FAIL to_pulse_time: got %0d want %0d", te_idx, TIMEOUT + 1); end
        if (te_cnt - te0 != 1) begin errors++; $display("FAIL to_pulse_count: got %0d want 1", te_cnt - te0); end
        if (ov_seen) begin errors++; $display("FAIL to_no_out_valid: got 1 want 0"); end
        if (ld_idx != int'(TIMEOUT) + 2) begin errors++; $display("FAIL to_next_load: got %0d want %0d", ld_idx, TIMEOUT + 2); end
        wait_out_valid(40, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL to_next_valid: got none want 1 within 40 cycles"); end
        if (bus.out_product !== 16'h000C) begin errors++; $display("FAIL to_next_product: got %h want 000c", bus.out_product); end
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int l0;
        bit ov_seen = 1'b0;
        bit seen;
        bus.out_ready = 1'b0;
        push_pair(8'h21, 8'h02);
        push_pair(8'h22, 8'h02);
        push_pair(8'h23, 8'h02);
        repeat (2) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2) begin errors++; $display("FAIL rm_queued: got %0d want 2", fifo_count); end
        #2 asyn_rst = 1'b0;
        #1;
        checks += 8;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b want 1", bus.in_ready); end
        if (bus.mul_load !== 1'b0) begin errors++; $display("FAIL rm_mul_load: got %b want 0", bus.mul_load); end
        if (bus.mul_a !== 8'h00) begin errors++; $display("FAIL rm_mul_a: got %h want 00", bus.mul_a); end
        if (bus.mul_b !== 8'h00) begin errors++; $display("FAIL rm_mul_b: got %h want 00", bus.mul_b); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_product !== 16'h0) begin errors++; $display("FAIL rm_out_product: got %h want 0000", bus.out_product); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rm_timeout_err: got %b want 0", timeout_err); end
        repeat (3) @(negedge clk);
        asyn_rst = 1'b1;
        bus.out_ready = 1'b1;
        l0 = load_cnt;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ov_seen = 1'b1;
        end
        checks += 2;
        if (ov_seen) begin errors++; $display("FAIL rm_no_output: got out_valid=1 want 0"); end
        if (load_cnt != l0) begin errors++; $display("FAIL rm_no_load: got %0d loads want 0", load_cnt - l0); end
        push_pair(8'h07, 8'h06);
        wait_out_valid(40, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL rm_new_valid: got none want 1 within 40 cycles"); end
        if (bus.out_product !== 16'h002A) begin errors++; $display("FAIL rm_new_product: got %h want 002a", bus.out_product); end
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stale();
        bit seen;
        mdl_stale = 1'b1;
        bus.out_ready = 1'b1;
        push_pair(8'h10, 8'h10);
        wait_out_valid(40, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL stale_first_valid: got none want 1 within 40 cycles"); end
        if (bus.out_product !== 16'h0100) begin errors++; $display("FAIL stale_first_product: got %h want 0100", bus.out_product); end
        @(negedge clk);
        push_pair(8'h03, 8'h05);
        wait_out_valid(40, seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL stale_second_valid: got none want 1 within 40 cycles"); end
        if (bus.out_product !== 16'h000F) begin errors++; $display("FAIL stale_second_product: got %h want 000f", bus.out_product); end
        mdl_stale = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_op();
        test_burst();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_stale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d want completion", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_operand_sequencer.md
MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

Interface
REQ-001 Parameter DEPTH, 4, operand FIFO depth in pairs (power of two, >= 2).
REQ-002 Parameter TIMEOUT, 15, maximum WAIT cycles for mul_valid before abort.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 asyn_rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  FIFO can accept a pair.
REQ-007 in_a, in_b  input  8 each  operand pair.
REQ-008 mul_load  output  1  one-cycle start pulse to the sequential multiplier.
REQ-009 mul_a, mul_b  output  8 each  operands to the multiplier, registered.
REQ-010 mul_product  input  16  multiplier result.
REQ-011 mul_valid  input  1  multiplier result valid.
REQ-012 out_valid  output  1  captured product available.
REQ-013 out_ready  input  1  downstream accepts product.
REQ-014 out_product  output  16  captured product, registered.
REQ-015 fifo_count  output  3  pairs queued, 0..DEPTH.
REQ-016 timeout_err  output  1  one-cycle pulse when a multiply times out.

Function
REQ-017 FIFO push on in_valid && in_ready; in_ready = (fifo_count < DEPTH), combinational from count.
REQ-018 FIFO pop only in LOAD; push and pop in one cycle leaves count unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states IDLE, LOAD, WAIT, HOLD.
REQ-020 IDLE -> LOAD when fifo_count > 0; otherwise stay.
REQ-021 LOAD lasts exactly one cycle: mul_load = 1, mul_a/mul_b = FIFO head (registered on entry), head popped; -> WAIT with timer cleared.
REQ-022 mul_load is 0 in every state except LOAD; mul_a/mul_b hold their last value outside LOAD.
REQ-023 WAIT: timer increments each cycle; mul_valid ignored while timer == 0 (stale valid from previous operation).
REQ-024 WAIT, timer >= 1 and mul_valid = 1: out_product <= mul_product, out_valid <= 1, -> HOLD.
REQ-025 WAIT, timer reaches TIMEOUT without qualifying mul_valid: timeout_err pulses one cycle, out_valid stays 0, -> IDLE; the pair is discarded.
REQ-026 Timeout check has priority lower than mul_valid: a qualifying mul_valid on the TIMEOUT cycle captures normally.
REQ-027 HOLD: out_valid = 1, out_product stable until out_valid && out_ready; then out_valid <= 0, -> IDLE.
REQ-028 Only one multiply outstanding; no mul_load issued in WAIT or HOLD, so the multiplier is never reloaded mid-operation.
REQ-029 Operand bits, including x/z, pass through to mul_a/mul_b unmodified; no checking.
REQ-030 Latency: pair pushed at edge T into empty FIFO with FSM in IDLE -> mul_load high in the cycle after edge T+1.
REQ-031 Products leave in push order; none dropped except on timeout or reset.

Reset
REQ-032 asyn_rst low, at any time including mid-WAIT or HOLD: FSM -> IDLE, FIFO emptied (fifo_count = 0, in_ready = 1), mul_load = 0, mul_a = mul_b = 0, out_valid = 0, out_product = 0, timeout_err = 0, timer = 0.
REQ-033 After release, first operation starts only on a new push; pre-reset pairs and in-flight products are lost.

Verification
REQ-034 Single op, multiplier model with 8-cycle latency: push (0xB7, 0xC5) -> one mul_load pulse with mul_a=0xB7, mul_b=0xC5; out_valid with out_product = 0x8CD3 (36051); held until out_ready.
REQ-035 Burst: push 5 pairs back-to-back with out_ready = 1 -> in_ready drops at fifo_count = 4; 5th pair accepted after first pop; 5 products in order, 0xB7*0xC5 = 0x8CD3 first, 0x95*0x67 = 0x3BF3 second.
REQ-036 Backpressure: out_ready = 0 for 20 cycles in HOLD -> out_valid and out_product stable; no mul_load issued; fifo_count unchanged.
REQ-037 Timeout: multiplier model never asserts valid -> timeout_err pulses once, TIMEOUT cycles after WAIT entry; next queued pair then loads normally.
REQ-038 Reset mid-operation: asyn_rst low 3 cycles into WAIT with 2 pairs queued -> all outputs at reset values immediately, asynchronously; no out_valid after release until new push.
REQ-039 Stale valid: mul_valid held high from the previous op during LOAD and first WAIT cycle -> not captured; the correct new product is captured.
